// File: rtl/req_arbiter8_pkg.sv
// ---------------------------------------------------------------------------
// req_arbiter8_pkg
// Shared definitions for the 8-way round-robin request arbiter:
//   NUM_REQ          requester count (8)
//   ID_W             width of a requester index (3)
//   MAX_HOLD_DEFAULT default maximum consecutive grant cycles per owner
//   arbState_t       arbiter FSM state encoding (IDLE / GRANT)
//   oneHot()         index -> one-hot grant vector
// ---------------------------------------------------------------------------
package req_arbiter8_pkg;

   localparam int NUM_REQ          = 8;
   localparam int ID_W             = 3;
   localparam int MAX_HOLD_DEFAULT = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arbState_t;

   function automatic logic [NUM_REQ-1:0] oneHot(input logic [ID_W-1:0] id);
      oneHot     = '0;
      oneHot[id] = 1'b1;
   endfunction

endpackage

// File: rtl/req_arbiter8_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick8
// Combinational round-robin picker. Searches mask starting at (last+1) mod 8,
// ascending with wrap, and returns the first set index.
//   mask [7:0]  candidate requesters
//   last [2:0]  most recently granted index (lowest priority this round)
//   id   [2:0]  winning index, valid only when any=1
//   any         at least one bit of mask is set
// ---------------------------------------------------------------------------
module rr_pick8
   import req_arbiter8_pkg::*;
(
   input  logic [NUM_REQ-1:0] mask,
   input  logic [ID_W-1:0]    last,
   output logic [ID_W-1:0]    id,
   output logic               any
);

   logic [ID_W-1:0]      start;
   logic [ID_W-1:0]      offset;
   logic [2*NUM_REQ-1:0] doubled;
   logic [NUM_REQ-1:0]   rotated;

   // Rotate so the search start lands on bit 0; 3-bit add wraps mod 8.
   assign start   = last + 3'd1;
   assign doubled = {mask, mask} >> start;
   assign rotated = doubled[NUM_REQ-1:0];

   // Priority encode: lowest set bit of the rotated vector wins.
   always_comb begin
      offset = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rotated[i]) offset = ID_W'(i);
      end
   end

   assign id  = start + offset;
   assign any = |mask;

endmodule

// File: rtl/req_arbiter8.sv
// ---------------------------------------------------------------------------
// req_arbiter8
// 8-requester round-robin arbiter with a per-owner hold limit.
//   iClk      clock, all state updates on the rising edge
//   iRst      synchronous active-high reset
//   iReq      level-held request vector, bit k = requester k
//   iDone     release strobe from the current owner
//   oGrant    registered one-hot grant, zero when idle
//   oGrantId  registered owner index, meaningful while oValid=1
//   oValid    high while a grant is active
//   oTimeout  one-cycle pulse after a release forced by the hold limit
// A release (iDone, owner drops its request, or hold limit) hands the grant
// straight to the next round-robin requester; with nobody else waiting the
// arbiter spends one cycle in IDLE before it may re-grant the same owner.
// ---------------------------------------------------------------------------
module req_arbiter8
   import req_arbiter8_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
   input  logic               iClk,
   input  logic               iRst,
   input  logic [NUM_REQ-1:0] iReq,
   input  logic               iDone,
   output logic [NUM_REQ-1:0] oGrant,
   output logic [ID_W-1:0]    oGrantId,
   output logic               oValid,
   output logic               oTimeout
);

   localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

   arbState_t          state, stateNext;
   logic [ID_W-1:0]    last, lastNext;
   logic [ID_W-1:0]    grantIdNext;
   logic [7:0]         holdCnt, holdCntNext;
   logic               timeoutNext;

   logic [NUM_REQ-1:0] pickMask;
   logic [ID_W-1:0]    pickId;
   logic               pickAny;
   logic               ownerReq;
   logic               holdExpired;
   logic               releaseEvt;

   // While granted, the current owner is excluded from the search so a
   // release never re-selects it in the same cycle.
   assign pickMask    = (state == GRANT) ? (iReq & ~oneHot(oGrantId)) : iReq;
   assign ownerReq    = iReq[oGrantId];
   assign holdExpired = (holdCnt == HOLD_LIMIT);
   assign releaseEvt  = iDone | ~ownerReq | holdExpired;

   rr_pick8 uPick (
      .mask (pickMask),
      .last (last),
      .id   (pickId),
      .any  (pickAny)
   );

   always_comb begin
      // NOTE: every output of this block gets a default before the case;
      // a path that leaves one unassigned would infer a latch.
      stateNext   = state;
      grantIdNext = oGrantId;
      lastNext    = last;
      holdCntNext = holdCnt;
      timeoutNext = 1'b0;

      unique case (state)
         IDLE: begin
            holdCntNext = '0;
            if (pickAny) begin
               stateNext   = GRANT;
               grantIdNext = pickId;
               lastNext    = pickId;
            end
         end
         GRANT: begin
            if (releaseEvt) begin
               // iDone takes precedence: a coincident timeout is not flagged.
               timeoutNext = holdExpired & ~iDone & ownerReq;
               holdCntNext = '0;
               if (pickAny) begin
                  grantIdNext = pickId;
                  lastNext    = pickId;
               end else begin
                  stateNext = IDLE;
               end
            end else if (holdCnt != 8'hFF) begin
               holdCntNext = holdCnt + 8'd1;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge iClk) begin
      // NOTE: non-blocking assignments only, so every register samples the
      // pre-edge values regardless of statement order.
      if (iRst) begin
         state    <= IDLE;
         oGrant   <= '0;
         oGrantId <= '0;
         oTimeout <= 1'b0;
         holdCnt  <= '0;
         last     <= ID_W'(NUM_REQ - 1);   // index 0 wins first after reset
      end else begin
         state    <= stateNext;
         oGrant   <= (stateNext == GRANT) ? oneHot(grantIdNext) : '0;
         oGrantId <= grantIdNext;
         oTimeout <= timeoutNext;
         holdCnt  <= holdCntNext;
         last     <= lastNext;
      end
   end

   assign oValid = (state == GRANT);

endmodule

// File: tb/tb_req_arbiter8.sv
// ---------------------------------------------------------------------------
// tb_req_arbiter8
// Directed bench for req_arbiter8 built with MAX_HOLD=4. A table of
// {reset, request, done -> valid, owner, timeout} rows walks through reset,
// wrap-around, owner drop, hold-limit timeout, done/timeout collision and
// reset mid-grant; a hand-written loop then checks the 0..7,0 fairness order.
// ---------------------------------------------------------------------------
module tb_req_arbiter8;

   localparam int HOLD = 4;

   logic       iClk = 1'b0;
   logic       iRst;
   logic [7:0] iReq;
   logic       iDone;
   logic [7:0] oGrant;
   logic [2:0] oGrantId;
   logic       oValid;
   logic       oTimeout;

   int total = 0;
   int bad   = 0;

   always #5 iClk = ~iClk;

   req_arbiter8 #(.MAX_HOLD(HOLD)) dut (
      .iClk     (iClk),
      .iRst     (iRst),
      .iReq     (iReq),
      .iDone    (iDone),
      .oGrant   (oGrant),
      .oGrantId (oGrantId),
      .oValid   (oValid),
      .oTimeout (oTimeout)
   );

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic       done;
      logic       expValid;
      logic [2:0] expId;
      logic       expTo;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, input logic [7:0] req, input logic done,
                               input logic expValid, input logic [2:0] expId, input logic expTo);
      vec_t v;
      v.rst = rst; v.req = req; v.done = done;
      v.expValid = expValid; v.expId = expId; v.expTo = expTo;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive inputs, let one rising edge pass, then sample 1 time unit later.
   task automatic step(input logic rst, input logic [7:0] req, input logic done);
      iRst = rst; iReq = req; iDone = done;
      @(posedge iClk);
      #1;
   endtask

   task automatic checkOut(input string tag, input int idx, input logic expValid,
                           input logic [2:0] expId, input logic expTo, input logic chkId);
      logic [7:0] expGrant;
      expGrant = expValid ? (8'b1 << expId) : 8'h00;
      check($sformatf("%s[%0d] valid", tag, idx), 32'(oValid), 32'(expValid));
      check($sformatf("%s[%0d] grant", tag, idx), 32'(oGrant), 32'(expGrant));
      check($sformatf("%s[%0d] timeout", tag, idx), 32'(oTimeout), 32'(expTo));
      if (chkId) check($sformatf("%s[%0d] id", tag, idx), 32'(oGrantId), 32'(expId));
   endtask

   initial begin
      iRst = 1'b1; iReq = '0; iDone = 1'b0;

      //               rst  req    done  valid id    to
      // reset held two cycles, then a single request at index 0
      vecs.push_back(mk(1, 8'h00, 0,    0,    3'd0, 0));
      vecs.push_back(mk(1, 8'hFF, 0,    0,    3'd0, 0));
      vecs.push_back(mk(0, 8'h01, 0,    1,    3'd0, 0));
      // iDone with nobody else waiting -> one IDLE cycle, then re-grant 0
      vecs.push_back(mk(0, 8'h01, 1,    0,    3'd0, 0));
      vecs.push_back(mk(0, 8'h01, 0,    1,    3'd0, 0));
      vecs.push_back(mk(0, 8'h00, 0,    0,    3'd0, 0));
      vecs.push_back(mk(0, 8'h00, 0,    0,    3'd0, 0));
      // make last=6, then wrap from 7 to 0, then owner drop hands to 5
      vecs.push_back(mk(0, 8'h40, 0,    1,    3'd6, 0));
      vecs.push_back(mk(0, 8'h00, 0,    0,    3'd6, 0));
      vecs.push_back(mk(0, 8'h21, 0,    1,    3'd0, 0));
      vecs.push_back(mk(0, 8'h20, 0,    1,    3'd5, 0));
      // 5 keeps requesting: held 4 cycles total, then forced release
      vecs.push_back(mk(0, 8'h20, 0,    1,    3'd5, 0));
      vecs.push_back(mk(0, 8'h20, 0,    1,    3'd5, 0));
      vecs.push_back(mk(0, 8'h20, 0,    1,    3'd5, 0));
      vecs.push_back(mk(0, 8'h20, 0,    0,    3'd5, 1));
      vecs.push_back(mk(0, 8'h20, 0,    1,    3'd5, 0));
      vecs.push_back(mk(0, 8'h00, 0,    0,    3'd5, 0));
      // timeout on index 7 alone
      vecs.push_back(mk(0, 8'h80, 0,    1,    3'd7, 0));
      vecs.push_back(mk(0, 8'h80, 0,    1,    3'd7, 0));
      vecs.push_back(mk(0, 8'h80, 0,    1,    3'd7, 0));
      vecs.push_back(mk(0, 8'h80, 0,    1,    3'd7, 0));
      vecs.push_back(mk(0, 8'h80, 0,    0,    3'd7, 1));
      vecs.push_back(mk(0, 8'h80, 0,    1,    3'd7, 0));
      // done coincides with the hold limit: release without timeout
      vecs.push_back(mk(0, 8'h80, 0,    1,    3'd7, 0));
      vecs.push_back(mk(0, 8'h80, 0,    1,    3'd7, 0));
      vecs.push_back(mk(0, 8'h80, 0,    1,    3'd7, 0));
      vecs.push_back(mk(0, 8'h80, 1,    0,    3'd7, 0));
      vecs.push_back(mk(0, 8'h80, 0,    1,    3'd7, 0));
      // owner 7 drops, direct hand-off to 3, then reset mid-grant
      vecs.push_back(mk(0, 8'h08, 0,    1,    3'd3, 0));
      vecs.push_back(mk(1, 8'hFF, 0,    0,    3'd0, 0));
      vecs.push_back(mk(0, 8'hFF, 0,    1,    3'd0, 0));
      vecs.push_back(mk(0, 8'hFF, 1,    1,    3'd1, 0));
      // timeout with other requesters: hand-off plus timeout pulse
      vecs.push_back(mk(0, 8'hFF, 0,    1,    3'd1, 0));
      vecs.push_back(mk(0, 8'hFF, 0,    1,    3'd1, 0));
      vecs.push_back(mk(0, 8'hFF, 0,    1,    3'd1, 0));
      vecs.push_back(mk(0, 8'hFF, 0,    1,    3'd2, 1));
      vecs.push_back(mk(0, 8'hFF, 0,    1,    3'd2, 0));
      vecs.push_back(mk(1, 8'h00, 0,    0,    3'd0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].req, vecs[i].done);
         checkOut("vec", i, vecs[i].expValid, vecs[i].expId, vecs[i].expTo,
                  vecs[i].expValid | vecs[i].rst);
      end

      // Fairness: all requesting, iDone every third cycle of each grant.
      step(0, 8'hFF, 0);
      checkOut("fair", 0, 1'b1, 3'd0, 1'b0, 1'b1);
      for (int k = 0; k < 8; k++) begin
         step(0, 8'hFF, 0);
         checkOut("fair", 3 * k + 1, 1'b1, 3'(k), 1'b0, 1'b1);
         step(0, 8'hFF, 0);
         checkOut("fair", 3 * k + 2, 1'b1, 3'(k), 1'b0, 1'b1);
         step(0, 8'hFF, 1);
         checkOut("fair", 3 * k + 3, 1'b1, 3'((k + 1) % 8), 1'b0, 1'b1);
      end

      step(1, 8'h00, 0);
      checkOut("final", 0, 1'b0, 3'd0, 1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/req_arbiter8.md
REQ_ARBITER8 -- requirements
Module: req_arbiter8

Interface
REQ-001 Parameter MAX_HOLD, default 16, SHALL set the maximum consecutive cycles one owner may hold the grant (legal range 2..255).
REQ-002 iClk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 iRst  input  1  reset; synchronous, active-high.
REQ-004 iReq  input  8  request vector; bit k is requester k, level-held while requesting.
REQ-005 iDone  input  1  current owner's release strobe; ignored when no grant is active.
REQ-006 oGrant  output  8  one-hot grant vector; all-zero when idle.
REQ-007 oGrantId  output  3  binary index of the owner; meaningful only when oValid=1.
REQ-008 oValid  output  1  high while a grant is active.
REQ-009 oTimeout  output  1  one-cycle pulse on the cycle the hold counter forces a release.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-011 All outputs SHALL be registered; oGrant, oGrantId and oValid SHALL change only on iClk edges.
REQ-012 In IDLE with iReq!=0, the next edge SHALL enter GRANT with the owner chosen round-robin, giving a 1-cycle request-to-grant latency.
REQ-013 Round-robin search SHALL start at index (last+1) mod 8, ascend, and wrap; "last" is the most recently granted index.
REQ-014 In IDLE with iReq==0, the arbiter SHALL stay in IDLE with outputs zero.
REQ-015 In GRANT, the grant SHALL be held while iReq[owner]=1, iDone=0 and hold count < MAX_HOLD-1.
REQ-016 A release event is iDone=1, or iReq[owner]=0, or the hold count reaching MAX_HOLD-1; any of these SHALL end the current grant at the next edge.
REQ-017 On a release, if iReq masked with bit owner cleared is non-zero, the next edge SHALL grant the round-robin winner directly (no idle cycle); otherwise the next edge SHALL go to IDLE.
REQ-018 On a release with no other requester, when the owner's iReq is still 1 (iDone or timeout case), the arbiter SHALL pass through one IDLE cycle and then may re-grant the same owner.
REQ-019 The hold counter SHALL be 8 bits, clear on every new grant, increment each GRANT cycle, and never wrap.
REQ-020 oTimeout SHALL assert for exactly the one cycle following a release caused solely by the hold counter (iDone=0 and iReq[owner]=1).
REQ-021 When timeout and iDone coincide, the release SHALL be treated as iDone and oTimeout SHALL stay 0.
REQ-022 "last" SHALL update to the new owner on each grant and SHALL hold its value through IDLE.
REQ-023 oGrant SHALL always equal one-hot(oGrantId) when oValid=1, and at most one bit of oGrant SHALL ever be set.

Reset
REQ-024 While iRst=1 at an edge, the state SHALL become IDLE, oGrant=0, oGrantId=0, oValid=0, oTimeout=0, hold count=0 and last=7, so that index 0 has first priority.
REQ-025 Asserting iRst mid-grant SHALL drop the grant at that edge regardless of iReq and iDone.
REQ-026 Arbitration SHALL resume on the first edge with iRst=0.

Structure
REQ-027 The shared header SHALL define the requester count 8, the ID width 3, the IDLE/GRANT state encodings and the MAX_HOLD default.
REQ-028 Exactly one sub-module, rr_pick8, SHALL be instantiated; it is combinational, takes (mask[7:0], last[2:0]) and produces (id[2:0], any), using a rotate followed by an 8-to-3 priority encode.

Verification
REQ-029 Reset scenario: hold iRst for 2 cycles, then iReq=8'b0000_0001 -> 1 cycle later oGrant=8'b0000_0001, oGrantId=0, oValid=1.
REQ-030 Fairness scenario: iReq=8'hFF held, iDone pulsed every 3rd cycle -> owner sequence 0,1,2,...,7,0 with no idle gaps.
REQ-031 Timeout scenario: MAX_HOLD=4, iReq=8'b1000_0000 held, iDone=0 -> grant to 7 for 4 cycles, then oTimeout=1 with the arbiter in IDLE for 1 cycle, then 7 is re-granted.
REQ-032 Wrap and drop scenario: last=6, iReq=8'b0010_0001 -> grant to 0; owner drops iReq[0] -> next edge grants 5.
REQ-033 Reset mid-operation: while granted to 3, assert iRst for 1 cycle with iReq=8'hFF -> oValid=0, then a grant to 0 on the first cycle after release of reset.
REQ-034 Simultaneous events: at hold count MAX_HOLD-1 with iDone=1 -> release occurs with oTimeout=0.
